// File: rtl/lookup_engine_pkg.sv
// Shared widths and table geometry for the exact-match lookup stage.
package lookup_engine_pkg;
   localparam int width_6B  = 48;
   localparam int width_4B  = 32;
   localparam int width_2B  = 16;

   localparam int PHV_LEN   = 8*width_6B + 8*width_4B + 8*width_2B + 5*20 + 256;
   localparam int KEY_LEN   = 2*width_6B + 2*width_4B + 2*width_2B + 5;

   localparam int ENTRY_NUM = 16;
   localparam int ADDR_W    = $clog2(ENTRY_NUM);
endpackage

// File: rtl/lookup_engine_prio_enc.sv
// Combinational priority encoder: lowest set bit wins, index 0 when nothing is set.
module prio_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = W'(i);
      end
   end

   assign any = |vec;
endmodule

// File: rtl/lookup_engine.sv
// Masked exact-match lookup against a flop-based table, two registered stages,
// with the PHV carried alongside unmodified.
module lookup_engine
   import lookup_engine_pkg::*;
#(
   parameter int STAGE     = 0,
   parameter int PHV_LEN   = lookup_engine_pkg::PHV_LEN,
   parameter int KEY_LEN   = lookup_engine_pkg::KEY_LEN,
   parameter int ENTRY_NUM = lookup_engine_pkg::ENTRY_NUM,
   parameter int ADDR_W    = lookup_engine_pkg::ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PHV_LEN-1:0] phv_in,
   input  logic               phv_valid_in,
   input  logic [KEY_LEN-1:0] key_in,
   input  logic               key_valid_in,
   input  logic [KEY_LEN-1:0] key_mask_in,
   input  logic               key_mask_valid_in,
   input  logic               cfg_wr_en,
   input  logic [ADDR_W-1:0]  cfg_wr_addr,
   input  logic [KEY_LEN-1:0] cfg_wr_key,
   input  logic               cfg_wr_vld,
   output logic [PHV_LEN-1:0] phv_out,
   output logic               phv_valid_out,
   output logic [ADDR_W-1:0]  action_addr_out,
   output logic               hit_out,
   output logic               action_valid_out
);
   if (STAGE < 0 || STAGE > 4) begin : g_bad_stage
      $error("lookup_engine: STAGE out of range");
   end
   if ((1 << ADDR_W) != ENTRY_NUM) begin : g_bad_depth
      $error("lookup_engine: ENTRY_NUM must equal 2**ADDR_W");
   end

   logic [KEY_LEN-1:0]   entry_key_reg [ENTRY_NUM];
   logic [ENTRY_NUM-1:0] entry_vld_reg;
   logic [KEY_LEN-1:0]   mask_reg;

   logic [ENTRY_NUM-1:0] match_vec;
   logic [ENTRY_NUM-1:0] s1_match_reg;
   logic [PHV_LEN-1:0]   s1_phv_reg;
   logic                 s1_phv_valid_reg;
   logic                 s1_key_valid_reg;

   logic [ADDR_W-1:0]    enc_idx;
   logic                 enc_any;

   // Configuration registers; writes land at the edge, so a same-cycle key sees old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRY_NUM; i++) entry_key_reg[i] <= '0;
         entry_vld_reg <= '0;
         mask_reg      <= '0;
      end else begin
         if (cfg_wr_en) begin
            entry_key_reg[cfg_wr_addr] <= cfg_wr_key;
            entry_vld_reg[cfg_wr_addr] <= cfg_wr_vld;
         end
         if (key_mask_valid_in) mask_reg <= key_mask_in;
      end
   end

   for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_match
      assign match_vec[gi] = entry_vld_reg[gi] &&
                             ((key_in & mask_reg) == (entry_key_reg[gi] & mask_reg));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_match_reg     <= '0;
         s1_phv_reg       <= '0;
         s1_phv_valid_reg <= 1'b0;
         s1_key_valid_reg <= 1'b0;
      end else begin
         s1_phv_valid_reg <= phv_valid_in;
         s1_key_valid_reg <= key_valid_in;
         if (key_valid_in) s1_match_reg <= match_vec;
         if (phv_valid_in) s1_phv_reg   <= phv_in;
      end
   end

   prio_enc #(
      .N (ENTRY_NUM),
      .W (ADDR_W)
   ) u_prio_enc (
      .vec (s1_match_reg),
      .idx (enc_idx),
      .any (enc_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phv_out          <= '0;
         phv_valid_out    <= 1'b0;
         action_addr_out  <= '0;
         hit_out          <= 1'b0;
         action_valid_out <= 1'b0;
      end else begin
         phv_valid_out    <= s1_phv_valid_reg;
         action_valid_out <= s1_key_valid_reg;
         if (s1_phv_valid_reg) phv_out <= s1_phv_reg;
         if (s1_key_valid_reg) begin
            action_addr_out <= enc_idx;
            hit_out         <= enc_any;
         end
      end
   end
endmodule

// File: tb/tb_lookup_engine.sv
// Directed scoreboard bench for lookup_engine: driver pushes expectations, monitor pops on valid.
module tb_lookup_engine;
   localparam int PHV_LEN = 1124;
   localparam int KEY_LEN = 197;
   localparam int ADDR_W  = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [PHV_LEN-1:0] phv_in = '0;
   logic               phv_valid_in = 1'b0;
   logic [KEY_LEN-1:0] key_in = '0;
   logic               key_valid_in = 1'b0;
   logic [KEY_LEN-1:0] key_mask_in = '0;
   logic               key_mask_valid_in = 1'b0;
   logic               cfg_wr_en = 1'b0;
   logic [ADDR_W-1:0]  cfg_wr_addr = '0;
   logic [KEY_LEN-1:0] cfg_wr_key = '0;
   logic               cfg_wr_vld = 1'b0;
   logic [PHV_LEN-1:0] phv_out;
   logic               phv_valid_out;
   logic [ADDR_W-1:0]  action_addr_out;
   logic               hit_out;
   logic               action_valid_out;

   lookup_engine dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .phv_in            (phv_in),
      .phv_valid_in      (phv_valid_in),
      .key_in            (key_in),
      .key_valid_in      (key_valid_in),
      .key_mask_in       (key_mask_in),
      .key_mask_valid_in (key_mask_valid_in),
      .cfg_wr_en         (cfg_wr_en),
      .cfg_wr_addr       (cfg_wr_addr),
      .cfg_wr_key        (cfg_wr_key),
      .cfg_wr_vld        (cfg_wr_vld),
      .phv_out           (phv_out),
      .phv_valid_out     (phv_valid_out),
      .action_addr_out   (action_addr_out),
      .hit_out           (hit_out),
      .action_valid_out  (action_valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PHV_LEN-1:0] phv;
      logic               hit;
      logic [ADDR_W-1:0]  addr;
      int                 cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [KEY_LEN-1:0] k_val;
   logic [KEY_LEN-1:0] ones;

   always @(posedge clk) cyc++;

   function automatic logic [PHV_LEN-1:0] rand_phv();
      logic [1151:0] tmp;
      for (int i = 0; i < 36; i++) tmp[i*32 +: 32] = $urandom;
      return tmp[PHV_LEN-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      key_valid_in      = 1'b0;
      phv_valid_in      = 1'b0;
      cfg_wr_en         = 1'b0;
      key_mask_valid_in = 1'b0;
   endtask

   task automatic set_key(input logic [KEY_LEN-1:0] k, input logic hit, input logic [ADDR_W-1:0] addr);
      exp_t e;
      e.phv  = rand_phv();
      e.hit  = hit;
      e.addr = addr;
      e.cyc  = cyc + 2;
      phv_in       = e.phv;
      key_in       = k;
      phv_valid_in = 1'b1;
      key_valid_in = 1'b1;
      sb_q.push_back(e);
   endtask

   task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [KEY_LEN-1:0] k, input logic v);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = a;
      cfg_wr_key  = k;
      cfg_wr_vld  = v;
   endtask

   task automatic set_mask(input logic [KEY_LEN-1:0] m);
      key_mask_in       = m;
      key_mask_valid_in = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (phv_out !== '0 || phv_valid_out !== 1'b0 || action_addr_out !== '0 ||
          hit_out !== 1'b0 || action_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL %s: got pv=%0b av=%0b hit=%0b addr=%0d phv_nonzero=%0b, required all zero",
                  tag, phv_valid_out, action_valid_out, hit_out, action_addr_out, |phv_out);
      end else begin
         $display("check %s: outputs at reset values", tag);
      end
   endtask

   // Monitor: compares every presented result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (action_valid_out || phv_valid_out)) begin
         checks++;
         if (action_valid_out !== phv_valid_out) begin
            errors++;
            $display("FAIL valid_align: action_valid=%0b phv_valid=%0b, required equal",
                     action_valid_out, phv_valid_out);
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: valid output at cycle %0d with nothing pending, required none", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (hit_out !== e.hit || action_addr_out !== e.addr || phv_out !== e.phv || cyc != e.cyc) begin
               errors++;
               $display("FAIL lookup: got hit=%0b addr=%0d phv_ok=%0b cyc=%0d, required hit=%0b addr=%0d cyc=%0d",
                        hit_out, action_addr_out, phv_out === e.phv, cyc, e.hit, e.addr, e.cyc);
            end else begin
               $display("check lookup: hit=%0b addr=%0d cyc=%0d ok", hit_out, action_addr_out, cyc);
            end
         end
      end
   end

   initial begin
      k_val = {5'h15, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 64'h1357_9BDF_2468_ACE0};
      ones  = '1;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      tick();

      // Empty table: miss, PHV passes through.
      set_key(k_val, 1'b0, 4'd0); tick();

      set_mask(ones); tick();
      set_wr(4'd5, k_val, 1'b1); tick();
      set_key(k_val, 1'b1, 4'd5); tick();
      set_key(k_val ^ 197'd1, 1'b0, 4'd0); tick();

      // Two identical entries: lowest index wins, then deletion exposes the other.
      set_wr(4'd5, k_val, 1'b0); tick();
      set_wr(4'd3, k_val, 1'b1); tick();
      set_wr(4'd9, k_val, 1'b1); tick();
      set_key(k_val, 1'b1, 4'd3); tick();
      set_wr(4'd3, k_val, 1'b0); tick();
      set_key(k_val, 1'b1, 4'd9); tick();

      // Partial mask on the low five bits.
      set_mask(197'h1F); tick();
      set_wr(4'd0, {~192'd0, 5'h1F}, 1'b1); tick();
      set_key(197'h1F, 1'b1, 4'd0); tick();
      set_key(197'h0E, 1'b0, 4'd0); tick();

      // Zero mask: every valid entry matches.
      set_mask('0); tick();
      set_key(197'd12345, 1'b1, 4'd0); tick();
      set_wr(4'd0, '0, 1'b0); tick();
      set_key(197'd777, 1'b1, 4'd9); tick();

      // Write and key in the same cycle: key sees the old table.
      set_mask(ones); tick();
      set_wr(4'd9, '0, 1'b0); tick();
      set_wr(4'd2, k_val, 1'b1); set_key(k_val, 1'b0, 4'd0); tick();
      set_key(k_val, 1'b1, 4'd2); tick();

      // Back-to-back alternating hits/misses with reset during the fifth.
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) set_key(k_val, 1'b1, 4'd2);
         else            set_key(k_val ^ 197'd2, 1'b0, 4'd0);
         tick();
      end
      set_key(k_val, 1'b1, 4'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      sb_q.delete();
      @(posedge clk);
      #1;
      key_valid_in = 1'b0;
      phv_valid_in = 1'b0;
      check_reset_outputs("held_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i % 2 == 0) set_key(k_val, 1'b0, 4'd0);
         else            set_key(k_val ^ 197'd2, 1'b0, 4'd0);
         tick();
      end

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
      end else begin
         $display("check drain: all results received");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
